student_fir_feeder: RTL

STUDENT_FIR_FEEDER -- requirements
Module: student_fir_feeder

---
 rtl/student_fir_feeder.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/student_fir_feeder.sv
// Sample FIFO feeding an FIR engine: each queued sample is presented with a
// fixed-width valid strobe, then the feeder waits (bounded) for the FIR to finish.
module student_fir_feeder #(
    parameter int DATA_SIZE      = 16,
    parameter int FIFO_DEPTH     = 8,
    parameter int STROBE_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES = 2048
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          enable_i,
    input  logic                          flush_i,
    input  logic                          sample_valid_i,
    input  logic [DATA_SIZE-1:0]          sample_i,
    output logic                          sample_ready_o,
    output logic                          valid_strobe_out,
    output logic [DATA_SIZE-1:0]          sample_out,
    input  logic                          compute_finished_in,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
    output logic                          timeout_o,
    output logic                          busy_o
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam int SW = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STROBE,
        S_WAIT_DONE,
        S_GAP
    } state_t;

    state_t               r_state;
    logic [DATA_SIZE-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0]        r_wr_ptr;
    logic [PW-1:0]        r_rd_ptr;
    logic [LW-1:0]        r_level;
    logic [SW-1:0]        r_strobe_cnt;
    logic [TW-1:0]        r_wait_cnt;
    logic                 r_done_seen;
    logic                 r_strobe;
    logic                 r_timeout;
    logic [DATA_SIZE-1:0] r_sample;

    logic w_ready;
    logic w_push;
    logic w_pop;
    logic w_done;

    assign w_ready = (r_level != LW'(FIFO_DEPTH)) && !flush_i;
    assign w_push  = sample_valid_i && w_ready;
    // GAP hands straight over to the next strobe so back-to-back runs take STROBE_CYCLES+2
    assign w_pop   = ((r_state == S_IDLE) || (r_state == S_GAP)) && enable_i &&
                     (r_level != '0) && !flush_i;
    assign w_done  = r_done_seen || compute_finished_in;

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= sample_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + LW'(1);
            end else if (!w_push && w_pop) begin
                r_level <= r_level - LW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= S_IDLE;
            r_strobe     <= 1'b0;
            r_sample     <= '0;
            r_strobe_cnt <= '0;
            r_wait_cnt   <= '0;
            r_done_seen  <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_GAP: begin
                    if (w_pop) begin
                        r_sample     <= r_mem[r_rd_ptr];
                        r_strobe     <= 1'b1;
                        r_strobe_cnt <= SW'(STROBE_CYCLES - 1);
                        r_wait_cnt   <= TW'(TIMEOUT_CYCLES - 1);
                        r_done_seen  <= 1'b0;
                        r_state      <= S_STROBE;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_STROBE: begin
                    if (r_wait_cnt != '0) begin
                        r_wait_cnt <= r_wait_cnt - TW'(1);
                    end
                    if (compute_finished_in) begin
                        r_done_seen <= 1'b1;
                    end
                    if (r_strobe_cnt == '0) begin
                        r_strobe <= 1'b0;
                        r_state  <= S_WAIT_DONE;
                    end else begin
                        r_strobe_cnt <= r_strobe_cnt - SW'(1);
                    end
                end
                S_WAIT_DONE: begin
                    if (w_done) begin
                        r_state <= S_GAP;
                    end else if (r_wait_cnt == '0) begin
                        r_timeout <= 1'b1;
                        r_state   <= S_GAP;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - TW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign sample_ready_o   = w_ready;
    assign valid_strobe_out = r_strobe;
    assign sample_out       = r_sample;
    assign fifo_level_o     = r_level;
    assign timeout_o        = r_timeout;
    assign busy_o           = (r_state != S_IDLE);

endmodule
